// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index type and
// the sequencing FSM state encoding.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEMWAIT  = 3'd1,
        REDIRECT = 3'd2,
        HALT     = 3'd3
    } hzstate_t;

    // One bit per latch/PC control; a zeroed struct is a full freeze.
    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } hzctl_t;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational load-use, taken-redirect and dcache-wait terms
// derived from the EX/MEM stage outputs and the ID register fields.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic     ex_dREN,
    input  logic     ex_regWr,
    input  regbits_t ex_regDst,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    input  logic     ex_branch,
    input  logic     ex_bne,
    input  logic     ex_equal,
    input  logic     ex_jump,
    input  logic     mem_dREN,
    input  logic     mem_dWEN,
    input  logic     dhit,
    output logic     ldhaz,
    output logic     taken,
    output logic     dwait
);

    // Register 0 is hardwired, so a load targeting it never stalls.
    assign ldhaz = ex_dREN && ex_regWr && (ex_regDst != '0) &&
                   ((ex_regDst == id_rs) || (id_uses_rt && (ex_regDst == id_rt)));

    assign taken = (ex_branch && (ex_equal ^ ex_bne)) || ex_jump;

    assign dwait = (mem_dREN || mem_dWEN) && !dhit;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencing (stall/flush/redirect/halt).
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int PERF_W           = 32,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  regbits_t    id_rs,
    input  regbits_t    id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_dREN,
    input  logic        ex_regWr,
    input  regbits_t    ex_regDst,
    input  logic        ex_branch,
    input  logic        ex_bne,
    input  logic        ex_equal,
    input  logic        ex_jump,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_halt,
    output logic        pc_en,
    output logic        pc_redirect,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        halt,
    output logic [2:0]  state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] wait_cnt
`endif
);

    // Out-of-range settings fall back to a single redirect bubble.
    localparam int BUBBLES = (REDIRECT_BUBBLES >= 1 && REDIRECT_BUBBLES <= 3 && PERF_W >= 1)
                             ? REDIRECT_BUBBLES : 1;
    localparam logic [1:0] BUBBLE_LOAD = 2'(BUBBLES - 1);

    hzstate_t   state, state_nx;
    logic [1:0] bub_cnt, bub_cnt_nx;
    hzctl_t     ctl;
    logic       ldhaz, taken, dwait;
`ifdef HAZARD_PERF_EN
    logic       ev_stall, ev_flush;
`endif

    hazard_detect u_detect (
        .ex_dREN    (ex_dREN),
        .ex_regWr   (ex_regWr),
        .ex_regDst  (ex_regDst),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_branch  (ex_branch),
        .ex_bne     (ex_bne),
        .ex_equal   (ex_equal),
        .ex_jump    (ex_jump),
        .mem_dREN   (mem_dREN),
        .mem_dWEN   (mem_dWEN),
        .dhit       (dhit),
        .ldhaz      (ldhaz),
        .taken      (taken),
        .dwait      (dwait)
    );

    // Priority chain: reset, halted, halt retiring, dcache wait, taken, redirect, load-use.
    always_comb begin
        ctl        = '0;
        state_nx   = state;
        bub_cnt_nx = bub_cnt;
`ifdef HAZARD_PERF_EN
        ev_stall   = 1'b0;
        ev_flush   = 1'b0;
`endif
        if (!nRST) begin
            ctl.ifid_flush  = 1'b1;
            ctl.idex_flush  = 1'b1;
            ctl.exmem_flush = 1'b1;
        end else if (state == HALT) begin
            state_nx = HALT;
        end else if (mem_halt) begin
            ctl.memwb_en = 1'b1;
            state_nx     = HALT;
        end else if (dwait) begin
            state_nx = MEMWAIT;
        end else if (taken) begin
            ctl.pc_en       = 1'b1;
            ctl.pc_redirect = 1'b1;
            ctl.ifid_flush  = 1'b1;
            ctl.idex_flush  = 1'b1;
            ctl.exmem_en    = 1'b1;
            ctl.memwb_en    = 1'b1;
            bub_cnt_nx      = BUBBLE_LOAD;
            state_nx        = (BUBBLE_LOAD != 2'd0) ? REDIRECT : RUN;
`ifdef HAZARD_PERF_EN
            ev_flush        = 1'b1;
`endif
        end else if (state == REDIRECT) begin
            ctl.pc_en      = ihit;
            ctl.ifid_en    = ihit;
            ctl.idex_flush = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
            if (ihit) begin
                if (bub_cnt == 2'd0) state_nx = RUN;
                else                 bub_cnt_nx = bub_cnt - 2'd1;
            end
        end else if (ldhaz) begin
            ctl.idex_flush = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
            state_nx       = RUN;
`ifdef HAZARD_PERF_EN
            ev_stall       = 1'b1;
`endif
        end else begin
            ctl.pc_en      = ihit;
            ctl.ifid_en    = ihit;
            ctl.ifid_flush = !ihit;
            ctl.idex_en    = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
            state_nx       = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            state   <= state_nx;
            bub_cnt <= bub_cnt_nx;
        end
    end

    assign pc_en       = ctl.pc_en;
    assign pc_redirect = ctl.pc_redirect;
    assign ifid_en     = ctl.ifid_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_en     = ctl.idex_en;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_en    = ctl.exmem_en;
    assign exmem_flush = ctl.exmem_flush;
    assign memwb_en    = ctl.memwb_en;
    assign halt        = (state == HALT);
    assign state_o     = state;

`ifdef HAZARD_PERF_EN
    // Saturating event counters, frozen once the core has halted.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else if (state != HALT) begin
            if (ev_stall && !(&stall_cnt))         stall_cnt <= stall_cnt + 1'b1;
            if (ev_flush && !(&flush_cnt))         flush_cnt <= flush_cnt + 1'b1;
            if ((state == MEMWAIT) && !(&wait_cnt)) wait_cnt  <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against an event-level reference model.
module tb_hazard_ctrl;

    localparam int RB = 2;

    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, id_uses_rt;
    logic [4:0] id_rs, id_rt, ex_regDst;
    logic       ex_dREN, ex_regWr, ex_branch, ex_bne, ex_equal, ex_jump;
    logic       mem_dREN, mem_dWEN, mem_halt;
    logic       pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, halt;
    logic [2:0] state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
    int          m_stall = 0, m_flush = 0, m_wait = 0;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: halted / waiting on dcache / redirect bubbles remaining.
    bit m_halted  = 1'b0;
    bit m_waiting = 1'b0;
    bit m_redir   = 1'b0;
    int m_left    = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.PERF_W(32), .REDIRECT_BUBBLES(RB)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dREN(ex_dREN), .ex_regWr(ex_regWr), .ex_regDst(ex_regDst),
        .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_equal(ex_equal), .ex_jump(ex_jump),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halt(halt), .state_o(state_o)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        ihit = 1'b1; dhit = 1'b0; id_uses_rt = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_regDst = 5'd0;
        ex_dREN = 1'b0; ex_regWr = 1'b0; ex_branch = 1'b0; ex_bne = 1'b0;
        ex_equal = 1'b0; ex_jump = 1'b0;
        mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        bit dw, lh, tk;
        logic e_pc, e_red, e_ifen, e_iff, e_iden, e_idf, e_exen, e_exf, e_wb;
        bit n_halted, n_waiting, n_redir;
        int n_left, e_state;

        dw = (mem_dREN || mem_dWEN) && !dhit;
        lh = ex_dREN && ex_regWr && (ex_regDst != 0) &&
             ((ex_regDst == id_rs) || (id_uses_rt && (ex_regDst == id_rt)));
        tk = (ex_branch && (ex_equal != ex_bne)) || ex_jump;
        {e_pc, e_red, e_ifen, e_iff, e_iden, e_idf, e_exen, e_exf, e_wb} = '0;
        n_halted = m_halted; n_waiting = m_waiting; n_redir = m_redir; n_left = m_left;
        e_state = m_halted ? 3 : (m_waiting ? 1 : (m_redir ? 2 : 0));

`ifdef HAZARD_PERF_EN
        if (nRST) begin
            cmp({tag, ".stall_cnt"}, stall_cnt, m_stall);
            cmp({tag, ".flush_cnt"}, flush_cnt, m_flush);
            cmp({tag, ".wait_cnt"},  wait_cnt,  m_wait);
        end
        if (nRST && !m_halted && m_waiting) m_wait++;
`endif

        if (!nRST) begin
            e_iff = 1; e_idf = 1; e_exf = 1;
            n_halted = 0; n_waiting = 0; n_redir = 0; n_left = 0;
`ifdef HAZARD_PERF_EN
            m_stall = 0; m_flush = 0; m_wait = 0;
`endif
        end else if (m_halted) begin
            n_halted = 1;
        end else if (mem_halt) begin
            e_wb = 1; n_halted = 1;
        end else if (dw) begin
            n_waiting = 1; n_redir = 0;
        end else if (tk) begin
            e_pc = 1; e_red = 1; e_iff = 1; e_idf = 1; e_exen = 1; e_wb = 1;
            n_waiting = 0; n_left = RB - 1; n_redir = (RB - 1) > 0;
`ifdef HAZARD_PERF_EN
            m_flush++;
`endif
        end else if (m_redir) begin
            e_pc = ihit; e_ifen = ihit; e_idf = 1; e_exen = 1; e_wb = 1;
            if (ihit) begin
                if (m_left == 0) n_redir = 0;
                else             n_left = m_left - 1;
            end
        end else if (lh) begin
            e_idf = 1; e_exen = 1; e_wb = 1; n_waiting = 0;
`ifdef HAZARD_PERF_EN
            m_stall++;
`endif
        end else begin
            e_pc = ihit; e_ifen = ihit; e_iff = !ihit; e_iden = 1; e_exen = 1; e_wb = 1;
            n_waiting = 0;
        end

        cmp({tag, ".pc_en"},       pc_en,       e_pc);
        cmp({tag, ".pc_redirect"}, pc_redirect, e_red);
        cmp({tag, ".ifid_en"},     ifid_en,     e_ifen);
        cmp({tag, ".ifid_flush"},  ifid_flush,  e_iff);
        cmp({tag, ".idex_en"},     idex_en,     e_iden);
        cmp({tag, ".idex_flush"},  idex_flush,  e_idf);
        cmp({tag, ".exmem_en"},    exmem_en,    e_exen);
        cmp({tag, ".exmem_flush"}, exmem_flush, e_exf);
        cmp({tag, ".memwb_en"},    memwb_en,    e_wb);
        if (nRST) begin
            cmp({tag, ".state_o"}, state_o, e_state);
            cmp({tag, ".halt"},    halt,    m_halted);
        end

        m_halted = n_halted; m_waiting = n_waiting; m_redir = n_redir; m_left = n_left;
    endtask

    task automatic applyStimulus(input string tag);
        @(negedge CLK);
        checkOutput(tag);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clearInputs();
        nRST = 1'b0;
        applyStimulus("reset0");
        applyStimulus("reset1");
        nRST = 1'b1;
        applyStimulus("run_ihit");
        ihit = 1'b0;
        applyStimulus("run_imiss");
        ihit = 1'b1;

        // Load-use on rs, on rt, and through register 0.
        ex_dREN = 1; ex_regWr = 1; ex_regDst = 5'd8; id_rs = 5'd8;
        applyStimulus("ldhaz_rs");
        clearInputs();
        applyStimulus("ldhaz_after");
        ex_dREN = 1; ex_regWr = 1; ex_regDst = 5'd0; id_rs = 5'd0;
        applyStimulus("ldhaz_r0");
        ex_regDst = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1;
        applyStimulus("ldhaz_rt");
        id_uses_rt = 0;
        applyStimulus("ldhaz_rt_unused");
        clearInputs();

        // beq taken, then redirect bubbles across icache misses.
        ex_branch = 1; ex_equal = 1;
        applyStimulus("beq_taken");
        clearInputs();
        ihit = 0;
        for (int i = 0; i < 3; i++) applyStimulus("redir_miss");
        ihit = 1;
        for (int i = 0; i < 3; i++) applyStimulus("redir_hit");
        ex_branch = 1; ex_bne = 1; ex_equal = 1;
        applyStimulus("bne_not_taken");
        clearInputs();

        // dcache wait with a jump held in EX until the dhit cycle.
        mem_dREN = 1; dhit = 0; ex_jump = 1;
        for (int i = 0; i < 5; i++) applyStimulus("dwait");
        dhit = 1;
        applyStimulus("dwait_release");
        clearInputs();
        for (int i = 0; i < 3; i++) applyStimulus("dwait_redir");

`ifdef HAZARD_PERF_EN
        nRST = 0; applyStimulus("perf_reset"); nRST = 1;
        for (int i = 0; i < 3; i++) begin
            ex_dREN = 1; ex_regWr = 1; ex_regDst = 5'd4; id_rs = 5'd4;
            applyStimulus("perf_stall");
            clearInputs();
        end
        for (int i = 0; i < 2; i++) begin
            ex_jump = 1; applyStimulus("perf_jump");
            ex_jump = 0; applyStimulus("perf_bub0"); applyStimulus("perf_bub1");
        end
        mem_dWEN = 1;
        for (int i = 0; i < 5; i++) applyStimulus("perf_wait");
        dhit = 1; applyStimulus("perf_dhit");
        clearInputs();
        @(negedge CLK);
        cmp("perf_stall_total", stall_cnt, 32'd3);
        cmp("perf_flush_total", flush_cnt, 32'd2);
        cmp("perf_wait_total",  wait_cnt,  32'd5);
`endif

        // Randomized traffic with occasional resets and halts.
        for (int i = 0; i < 400; i++) begin
            nRST       = ($urandom_range(0, 39) != 0);
            ihit       = ($urandom_range(0, 3) != 0);
            dhit       = $urandom_range(0, 1) == 1;
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rt = $urandom_range(0, 1) == 1;
            ex_dREN    = $urandom_range(0, 2) == 0;
            ex_regWr   = $urandom_range(0, 3) != 0;
            ex_regDst  = 5'($urandom_range(0, 3));
            ex_branch  = $urandom_range(0, 5) == 0;
            ex_bne     = $urandom_range(0, 1) == 1;
            ex_equal   = $urandom_range(0, 1) == 1;
            ex_jump    = $urandom_range(0, 11) == 0;
            mem_dREN   = $urandom_range(0, 4) == 0;
            mem_dWEN   = $urandom_range(0, 7) == 0;
            mem_halt   = $urandom_range(0, 149) == 0;
            applyStimulus("rand");
        end

        // Halt retires, sticks, and only reset clears it.
        clearInputs();
        nRST = 0; applyStimulus("pre_halt_reset"); nRST = 1;
        mem_halt = 1;
        applyStimulus("mem_halt");
        mem_halt = 0;
        for (int i = 0; i < 4; i++) applyStimulus("halted");
        ex_jump = 1; mem_dREN = 1;
        applyStimulus("halted_busy");
        clearInputs();
        nRST = 0;
        applyStimulus("halt_reset");
        nRST = 1;
        applyStimulus("post_halt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Drives enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable/redirect.
- Resolves load-use hazards, dcache wait, branch/jump redirect resolved in EX, and halt.
- Sits beside the datapath; consumes the execute-stage outputs (equal, regDst_next, dREN) and instruction/data hit signals.

Parameters:
- PERF_W, 32, width of optional performance counters.
- REDIRECT_BUBBLES, 1, cycles REDIRECT holds ID/EX flushed after a taken branch/jump (1..3).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- ihit  in  1  icache returned instruction this cycle.
- dhit  in  1  dcache completed MEM-stage access this cycle.
- id_rs  in  5  rs field of instruction in ID (regbits_t).
- id_rt  in  5  rt field of instruction in ID (regbits_t).
- id_uses_rt  in  1  ID instruction reads rt.
- ex_dREN  in  1  instruction in EX is a load.
- ex_regWr  in  1  EX instruction writes the register file.
- ex_regDst  in  5  destination of EX instruction.
- ex_branch  in  1  EX holds beq/bne.
- ex_bne  in  1  EX branch is bne.
- ex_equal  in  1  equal flag from execute.
- ex_jump  in  1  EX holds jr/jal/j resolved in EX.
- mem_dREN  in  1  MEM-stage load pending.
- mem_dWEN  in  1  MEM-stage store pending.
- mem_halt  in  1  halt opcode reached MEM.
- pc_en  out  1  PC register update enable.
- pc_redirect  out  1  select EX-computed target for next PC.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  IF/ID load bubble.
- idex_en  out  1  ID/EX latch enable.
- idex_flush  out  1  ID/EX load bubble.
- exmem_en  out  1  EX/MEM latch enable.
- exmem_flush  out  1  EX/MEM load bubble.
- memwb_en  out  1  MEM/WB latch enable.
- halt  out  1  sticky processor halt.
- state_o  out  3  current FSM state (hzstate_t).

Behaviour:
- FSM states: RUN, MEMWAIT, REDIRECT, HALT. Register updates on CLK rising edge.
- Reset (nRST=0 sampled): state←RUN, halt←0, redirect counter←0, perf counters←0. Outputs during reset cycle: all *_en=0, all *_flush=1, pc_en=0, pc_redirect=0.
- Combinational outputs; per-cycle priority: HALT > dcache wait > redirect > load-use > normal.
- dwait = (mem_dREN|mem_dWEN) & ~dhit. ldhaz = ex_dREN & ex_regWr & ex_regDst≠0 & (ex_regDst==id_rs | (id_uses_rt & ex_regDst==id_rt)). taken = (ex_branch & (ex_equal ^ ex_bne)) | ex_jump.
- HALT: all enables 0, flushes 0, halt=1; exits only via reset.
- mem_halt=1 in any state: memwb_en=1 this cycle (halt retires), next state HALT.
- dwait (RUN/REDIRECT): all enables and pc_en 0, no flush; next MEMWAIT. MEMWAIT holds freeze until dhit, then behaves as RUN for that cycle and returns to RUN (or REDIRECT if taken).
- taken & ~dwait: pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1; counter←REDIRECT_BUBBLES-1; next REDIRECT if counter>0, else RUN.
- REDIRECT: idex_flush=1, ifid_en=ihit, pc_en=ihit; counter decrements on ihit; at 0 with ihit → RUN. Cycles without ihit do not decrement.
- ldhaz (RUN, no higher event): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1; remains RUN (bubble resolves next cycle).
- Normal RUN: pc_en=ihit, ifid_en=ihit, idex_en=1, exmem_en=1, memwb_en=1; ifid_flush=~ihit (bubble on icache miss).
- taken and ldhaz together: taken wins (ID instruction is squashed).
- Register 0 never creates a hazard.

Optional Feature:
- HAZARD_PERF_EN: when defined, adds outputs stall_cnt, flush_cnt, wait_cnt (PERF_W each), counting ldhaz-bubble cycles, taken redirects and MEMWAIT cycles. Counters saturate at all-ones, freeze in HALT, and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared control_unit_pkg additions: hzstate_t enum (RUN=0, MEMWAIT=1, REDIRECT=2, HALT=3); reuse regbits_t/word_t from cpu_types_pkg.
- Sub-module hazard_detect: purely combinational ldhaz/taken/dwait terms. FSM and outputs stay in hazard_ctrl.

Test Plan:
- Reset held 2 cycles with ihit=1 → all *_en=0, *_flush=1; after release with ihit=1 → pc_en=1, state_o=RUN.
- lw to $t0 in EX, ID reads rs=$t0 → one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal. Same case with ex_regDst=0 → no stall.
- beq with ex_equal=1 → pc_redirect=1, ifid_flush=idex_flush=1; REDIRECT_BUBBLES=2 with ihit low 3 cycles → stays REDIRECT until two ihits.
- mem_dREN=1, dhit=0 for 4 cycles → all enables 0 for 4 cycles in MEMWAIT; dhit=1 → RUN. Concurrent taken branch is held and redirects on the dhit cycle.
- mem_halt=1 → memwb_en=1 that cycle, then halt=1 and all enables 0 indefinitely; nRST=0 → back to RUN.
- With HAZARD_PERF_EN: 3 load-use stalls, 2 redirects, 5 wait cycles → stall_cnt=3, flush_cnt=2, wait_cnt=5.
